// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core load/store
// path and a DMA/debug requester. The core normally wins. A starvation counter
// forces the DMA through after a bounded number of lost contested cycles, and
// dma_lock lets the DMA keep ownership for a bounded burst.
module dmem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MAX_STARVE = 4,
    parameter int LOCK_MAX   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    input  logic          dma_lock,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int SW = (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);
    localparam int LW = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DMA  = 1'b1
    } owner_t;

    owner_t        owner_q, owner_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [LW-1:0] lock_q, lock_d;
    logic          core_rvalid_q, dma_rvalid_q;
    logic          lock_phase;
    logic          forced;

    // A lock-phase grant continues a burst the DMA already owns; a forced grant
    // breaks the core's priority once the DMA has lost too many cycles in a row.
    assign lock_phase = dma_req & dma_lock & (owner_q == OWN_DMA) & (lock_q < LW'(LOCK_MAX));
    assign forced     = dma_req & (starve_q == SW'(MAX_STARVE));

    // State register: last owner, starvation count and lock burst length.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q  <= OWN_CORE;
            starve_q <= '0;
            lock_q   <= '0;
        end else begin
            owner_q  <= owner_d;
            starve_q <= starve_d;
            lock_q   <= lock_d;
        end
    end

    // Next-state logic derived from this cycle's grants.
    always_comb begin
        owner_d  = owner_q;
        starve_d = starve_q;
        lock_d   = lock_q;

        if (dma_gnt) begin
            owner_d = OWN_DMA;
        end else if (core_gnt) begin
            owner_d = OWN_CORE;
        end

        if (dma_gnt || !dma_req) begin
            starve_d = '0;
        end else if (core_gnt && (starve_q != SW'(MAX_STARVE))) begin
            starve_d = starve_q + SW'(1);
        end

        if (core_gnt) begin
            lock_d = '0;
        end else if (dma_gnt) begin
            lock_d = lock_phase ? (lock_q + LW'(1)) : LW'(1);
        end
    end

    // Output logic: grants (dropped while in reset) and the memory port mux.
    always_comb begin
        core_gnt = 1'b0;
        dma_gnt  = 1'b0;
        if (!rst) begin
            if (lock_phase || forced) begin
                dma_gnt = 1'b1;
            end else begin
                core_gnt = core_req;
                dma_gnt  = dma_req & ~core_req;
            end
        end

        if (dma_gnt) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end else begin
            mem_we    = core_gnt & core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end
    end

    // Read-valid strobes line up with the memory's one-cycle registered read.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_rvalid_q <= 1'b0;
            dma_rvalid_q  <= 1'b0;
        end else begin
            core_rvalid_q <= core_gnt & ~core_we;
            dma_rvalid_q  <= dma_gnt & ~dma_we;
        end
    end

    // A load granted just before reset must not report data during reset.
    assign core_rvalid = core_rvalid_q & ~rst;
    assign dma_rvalid  = dma_rvalid_q & ~rst;
    assign rdata       = mem_rdata;

endmodule
